// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay mixer: FSM states, alpha table,
// RGB field positions and the default transparent key colour.
package overlay_pkg;

    typedef enum logic {SYNC, RUN} state_t;

    localparam int CH_W = 8;
    localparam int R_LO = 16;
    localparam int G_LO = 8;
    localparam int B_LO = 0;

    localparam logic [23:0] KEY_COLOR_DEFAULT = 24'h00FF00;

    // Alpha is in quarters so 4 means fully opaque overlay.
    function automatic logic [2:0] alpha_lut(input logic [1:0] sel);
        case (sel)
            2'b00:   return 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/overlay_blend_channel.sv
// One 8-bit colour channel: (ovl*a + bg*(4-a)) >> 2, registered output.
// Latency 1 cycle; no backpressure.
module overlay_blend_channel
    import overlay_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH_W-1:0] ovl,
    input  logic [CH_W-1:0] bg,
    input  logic [2:0]      alpha,
    output logic [CH_W-1:0] blend
);

    logic [2:0]  inv_alpha;
    logic [10:0] ovl_term;
    logic [10:0] bg_term;
    logic [10:0] sum;

    always_comb begin
        inv_alpha = 3'd4 - alpha;
        ovl_term  = 11'(ovl) * 11'(alpha);
        bg_term   = 11'(bg) * 11'(inv_alpha);
        sum       = ovl_term + bg_term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blend <= '0;
        else        blend <= CH_W'(sum >> 2);
    end

endmodule

// File: rtl/overlay_mixer.sv
// Blends FIFO overlay pixels onto a background colour inside a fixed window.
// Latency 2 cycles; pixReady only in window while RUN, starvation drops to SYNC.
module overlay_mixer
    import overlay_pkg::*;
#(
    parameter int          hBusWidth = 12,
    parameter int          vBusWidth = 12,
    parameter int          OVL_X     = 0,
    parameter int          OVL_Y     = 0,
    parameter int          OVL_W     = 640,
    parameter int          OVL_H     = 480,
    parameter logic [23:0] KEY_COLOR = KEY_COLOR_DEFAULT
) (
    input  logic                 clock_50,
    input  logic                 masterReset_n,
    input  logic                 deIn,
    input  logic                 hsyncIn,
    input  logic                 vsyncIn,
    input  logic [hBusWidth-1:0] hCount,
    input  logic [vBusWidth-1:0] vCount,
    input  logic [23:0]          pixData,
    input  logic                 pixValid,
    output logic                 pixReady,
    input  logic [23:0]          bgColor,
    input  logic [3:0]           sw,
    input  logic                 key0,
    output logic [23:0]          rgbOut,
    output logic                 deOut,
    output logic                 hsyncOut,
    output logic                 vsyncOut,
    output logic                 frameStart,
    output logic                 underflow
);

    // One extra bit so OVL_X+OVL_W cannot wrap at the counter width.
    localparam int X_END_I = OVL_X + OVL_W;
    localparam int Y_END_I = OVL_Y + OVL_H;
    localparam logic [hBusWidth:0] X_LO = OVL_X[hBusWidth:0];
    localparam logic [hBusWidth:0] X_HI = X_END_I[hBusWidth:0];
    localparam logic [vBusWidth:0] Y_LO = OVL_Y[vBusWidth:0];
    localparam logic [vBusWidth:0] Y_HI = Y_END_I[vBusWidth:0];

    state_t      state, state_nxt;
    logic        vsync_d, vs_rise, hit, take, starve, keyed;
    logic [3:0]  cfg;
    logic [2:0]  alpha_eff;
    logic [hBusWidth:0] h_ext;
    logic [vBusWidth:0] v_ext;

    logic [23:0] s1_ovl, s1_bg;
    logic [2:0]  s1_alpha;
    logic        s1_de, s1_hs, s1_vs;

    always_comb begin
        h_ext     = {1'b0, hCount};
        v_ext     = {1'b0, vCount};
        hit       = deIn && (h_ext >= X_LO) && (h_ext < X_HI)
                         && (v_ext >= Y_LO) && (v_ext < Y_HI);
        vs_rise   = vsyncIn & ~vsync_d;
        pixReady  = (state == RUN) & hit;
        take      = pixReady & pixValid;
        starve    = pixReady & ~pixValid;
        keyed     = cfg[2] & (pixData == KEY_COLOR);
        alpha_eff = (cfg[3] & take & ~keyed) ? alpha_lut(cfg[1:0]) : 3'd0;

        // Starvation wins over a coincident vsync rise.
        state_nxt = state;
        if (state == RUN) begin
            if (starve) state_nxt = SYNC;
        end else if (vs_rise) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clock_50 or negedge masterReset_n) begin
        if (!masterReset_n) begin
            state      <= SYNC;
            vsync_d    <= 1'b0;
            cfg        <= '0;
            frameStart <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_nxt;
            vsync_d    <= vsyncIn;
            frameStart <= vs_rise;
            if (vs_rise) cfg <= sw;
            if (starve)    underflow <= 1'b1;
            else if (key0) underflow <= 1'b0;
        end
    end

    // Stage 1: zeroing bg outside DE makes the blend produce black there.
    always_ff @(posedge clock_50 or negedge masterReset_n) begin
        if (!masterReset_n) begin
            s1_ovl   <= '0;
            s1_bg    <= '0;
            s1_alpha <= '0;
            s1_de    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            deOut    <= 1'b0;
            hsyncOut <= 1'b0;
            vsyncOut <= 1'b0;
        end else begin
            s1_ovl   <= take ? pixData : 24'h0;
            s1_bg    <= deIn ? bgColor : 24'h0;
            s1_alpha <= alpha_eff;
            s1_de    <= deIn;
            s1_hs    <= hsyncIn;
            s1_vs    <= vsyncIn;
            deOut    <= s1_de;
            hsyncOut <= s1_hs;
            vsyncOut <= s1_vs;
        end
    end

    overlay_blend_channel u_blend_r (
        .clk   (clock_50),
        .rst_n (masterReset_n),
        .ovl   (s1_ovl[R_LO +: CH_W]),
        .bg    (s1_bg[R_LO +: CH_W]),
        .alpha (s1_alpha),
        .blend (rgbOut[R_LO +: CH_W])
    );

    overlay_blend_channel u_blend_g (
        .clk   (clock_50),
        .rst_n (masterReset_n),
        .ovl   (s1_ovl[G_LO +: CH_W]),
        .bg    (s1_bg[G_LO +: CH_W]),
        .alpha (s1_alpha),
        .blend (rgbOut[G_LO +: CH_W])
    );

    overlay_blend_channel u_blend_b (
        .clk   (clock_50),
        .rst_n (masterReset_n),
        .ovl   (s1_ovl[B_LO +: CH_W]),
        .bg    (s1_bg[B_LO +: CH_W]),
        .alpha (s1_alpha),
        .blend (rgbOut[B_LO +: CH_W])
    );

endmodule

// File: doc/overlay_mixer.md
# overlay_mixer

Pixel-path stage directly downstream of the HDMI timing generator: consumes its `DE`/`HSYNC`/`VSYNC` and pixel counters, pulls overlay-image pixels from the DDR fetch FIFO over a valid/ready handshake, and blends them onto a background colour inside a programmable window. The output is 24-bit RGB plus delayed syncs, aligned for the HDMI transmitter. It also issues a per-frame restart pulse to the fetcher and latches FIFO underflow.

## Interface
- `hBusWidth`, 12, horizontal counter width
- `vBusWidth`, 12, vertical counter width
- `OVL_X`, 0, window left column (inclusive)
- `OVL_Y`, 0, window top row (inclusive)
- `OVL_W`, 640, window width in pixels (≥1)
- `OVL_H`, 480, window height in lines (≥1)
- `KEY_COLOR`, 24'h00FF00, transparent colour used when keying is enabled

- `clock_50` in 1: pixel clock.
- `masterReset_n` in 1: asynchronous, active-low reset.
- `deIn`, `hsyncIn`, `vsyncIn` in 1 each: timing from the generator. All are active-high.
- `hCount` in hBusWidth, `vCount` in vBusWidth: current pixel position, aligned with `deIn`.
- `pixData` in 24: overlay pixel {R,G,B}.
- `pixValid` in 1: FIFO has a pixel.
- `pixReady` out 1: mixer consumes `pixData` this cycle.
- `bgColor` in 24: background colour.
- `sw` in 4: [1:0] alpha select, [2] colour-key enable, [3] overlay enable.
- `key0` in 1: clear the underflow flag. Level input, already latched by the board.
- `rgbOut` out 24, `deOut`/`hsyncOut`/`vsyncOut` out 1 each: outputs to the transmitter.
- `frameStart` out 1: one-cycle pulse at each `vsyncIn` rising edge. The fetcher flushes and restarts on it.
- `underflow` out 1: sticky FIFO-starvation flag.

## Operation
- `hit` = `deIn` & `hCount` ∈ [OVL_X, OVL_X+OVL_W) & `vCount` ∈ [OVL_Y, OVL_Y+OVL_H). Compare at counter width plus 1 bit so the window end cannot wrap.
- States:
  - SYNC (reset state): `pixReady`=0.
  - RUN: `pixReady` = `hit`, combinational.
  - A pixel transfers when `pixValid` & `pixReady`.
- Transitions:
  - SYNC → RUN on a `vsyncIn` rising edge.
  - RUN stays in RUN on a `vsyncIn` rising edge.
  - RUN → SYNC on underflow, defined as `hit` & !`pixValid`. The underflowing pixel and the rest of that frame show the background only. `underflow` is set.
- `frameStart` fires on every `vsyncIn` rising edge in either state.
- `sw` is sampled into a config register on the `vsyncIn` rising edge only. Config changes never tear mid-frame. The config reset value is 0.
- Pixels are consumed in the window whenever the state is RUN, even if alpha is 0 or the overlay is disabled. This keeps the FIFO aligned.
- Alpha a from cfg[1:0]: 00→0, 01→1, 10→2, 11→4.
- Effective a = 0 if cfg[3]=0, if no pixel was taken this cycle, or if cfg[2]=1 and `pixData`==KEY_COLOR.
- Per channel: out = (ovl·a + bg·(4−a)) >> 2.
  - Products are 11 bits and the sum is ≤1020.
  - The result is 8 bits with no saturation needed.
- `underflow` clears when `key0`=1. If set and clear coincide, set wins.
- Outside `deIn`, `rgbOut` = 0.

## Timing
- Latency is 2 cycles.
  - Stage 1 registers the selected pixel, effective alpha, bg, and syncs.
  - Stage 2 registers the blend result.
- `deOut`/`hsyncOut`/`vsyncOut` are the inputs delayed by exactly 2 cycles. `rgbOut` aligns with `deOut`.
- `pixReady` and the underflow decision are combinational in cycle 0. The state updates at the next edge.
- Reset (asynchronous, any time, including mid-line):
  - All outputs are 0, pipeline contents are 0, state is SYNC, config is 0, `underflow` is 0.
  - After release, the mixer waits for the next `vsyncIn` rise before consuming anything.
- A `vsyncIn` rise in the same cycle as a `hit`/underflow: underflow takes effect first (state → SYNC). `frameStart` still pulses. The next rise re-enters RUN.

## Structure
- Package `overlay_pkg`:
  - State enum {SYNC, RUN}.
  - Alpha LUT function (2 bits → 3 bits).
  - RGB field slicing constants.
  - Default KEY_COLOR.
- Sub-module `overlay_blend_channel`: one 8-bit blend with registered output, instantiated 3×.

## Test plan
- Reset mid-frame with `pixValid`=1 → all outputs 0, `pixReady` stays 0 until the first `vsyncIn` rise. That rise gives `frameStart`=1 for exactly one cycle.
- OVL_X=2, OVL_W=3, cfg=11 with overlay enabled, FIFO always valid, `pixData`=FF0000, bg=0000FF → `pixReady` high for hCount 2..4 only. `rgbOut`=FF0000 exactly 2 cycles later, 0000FF elsewhere in `deIn`.
- Alpha 10, ovl=FFFFFF, bg=000000 → 7F7F7F. Alpha 01 → 3F3F3F. Alpha 00 → 000000, with pixels still consumed.
- Keying on, `pixData`=00FF00 → bg shown. `pixData`=00FE00 → blended.
- Drop `pixValid` at the third window pixel → `underflow`=1, bg for the rest of the frame, `pixReady`=0 until the next vsync rise. `key0`=1 → `underflow` cleared.
- Change `sw` mid-frame → output unchanged until after the next `vsyncIn` rise.
